// File: rtl/dcf77_timekeeper.sv
// Local calendar clock disciplined by DCF77 frames: free-runs from the 10 ms
// enable, loads decoded frames on sync and tracks lock/holdover quality.
module dcf77_timekeeper #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MISS_MIN      = 2,
    parameter int HOLDOVER_MIN  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        sync,
    input  logic [58:0] data_hold,
    output logic [6:0]  sec,
    output logic [6:0]  min,
    output logic [5:0]  hour,
    output logic [5:0]  day,
    output logic [2:0]  wday,
    output logic [4:0]  month,
    output logic [7:0]  year,
    output logic        cest,
    output logic        sec_tick,
    output logic        min_tick,
    output logic [1:0]  status,
    output logic        time_valid
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] CAND_LIM = 8'd2;
    localparam logic [7:0] MISS_LIM = 8'(MISS_MIN);
    localparam logic [7:0] HOLD_LIM = 8'(HOLDOVER_MIN);

    typedef enum logic [1:0] {
        ST_UNSYNC    = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_HOLDOVER  = 2'd3
    } state_t;

    state_t        state_q;
    logic          time_valid_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    sec_q, sec_d, min_q, min_d;
    logic [5:0]    hour_q, hour_d, day_q, day_d;
    logic [2:0]    wday_q, wday_d;
    logic [4:0]    month_q, month_d;
    logic [7:0]    year_q, year_d;
    logic          cest_q, cest_d;
    logic [7:0]    miss_q, miss_d;
    logic          sec_tick_q, sec_tick_d, min_tick_q, min_tick_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    function automatic logic [7:0] month_len(input logic [4:0] m, input logic [7:0] y);
        logic leap;
        leap = (!y[4] && (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8)) ||
               ( y[4] && (y[3:0] == 4'd2 || y[3:0] == 4'd6));
        case (m)
            5'h04, 5'h06, 5'h09, 5'h11: return 8'h30;
            5'h02:                      return leap ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    logic [6:0] f_min;
    logic [5:0] f_hour, f_day;
    logic [2:0] f_wday;
    logic [4:0] f_month;
    logic [7:0] f_year;
    logic       frame_match;
    logic [7:0] sec_inc, min_inc, hour_inc, day_inc, month_inc, year_inc;
    logic       unused_bits;

    assign f_min   = data_hold[27:21];
    assign f_hour  = data_hold[34:29];
    assign f_day   = data_hold[41:36];
    assign f_wday  = data_hold[44:42];
    assign f_month = data_hold[49:45];
    assign f_year  = data_hold[57:50];
    assign unused_bits = ^{data_hold[58], data_hold[35], data_hold[28],
                           data_hold[20:18], data_hold[16:0]};

    // CANDIDATE confirmation compares against the running (pre-load) time.
    assign frame_match = (f_min == min_q) && (f_hour == hour_q) && (f_day == day_q) &&
                         (f_wday == wday_q) && (f_month == month_q) && (f_year == year_q);

    assign sec_inc   = bcd_inc({1'b0, sec_q});
    assign min_inc   = bcd_inc({1'b0, min_q});
    assign hour_inc  = bcd_inc({2'b00, hour_q});
    assign day_inc   = bcd_inc({2'b00, day_q});
    assign month_inc = bcd_inc({3'b000, month_q});
    assign year_inc  = bcd_inc(year_q);

    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_d      = day_q;
        wday_d     = wday_q;
        month_d    = month_q;
        year_d     = year_q;
        cest_d     = cest_q;
        miss_d     = miss_q;
        sec_tick_d = 1'b0;
        min_tick_d = 1'b0;
        if (clk_en && sync) begin
            presc_d = '0;
            sec_d   = 7'h00;
            min_d   = f_min;
            hour_d  = f_hour;
            day_d   = f_day;
            wday_d  = f_wday;
            month_d = f_month;
            year_d  = f_year;
            cest_d  = data_hold[17];
            miss_d  = 8'd0;
        end else if (clk_en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (sec_q == 7'h59) begin
                    sec_d      = 7'h00;
                    min_tick_d = 1'b1;
                    if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
                    if (min_q == 7'h59) begin
                        min_d = 7'h00;
                        if (hour_q == 6'h23) begin
                            hour_d = 6'h00;
                            wday_d = (wday_q == 3'd7) ? 3'd1 : wday_q + 3'd1;
                            if ({2'b00, day_q} == month_len(month_q, year_q)) begin
                                day_d = 6'h01;
                                if (month_q == 5'h12) begin
                                    month_d = 5'h01;
                                    year_d  = (year_q == 8'h99) ? 8'h00 : year_inc;
                                end else begin
                                    month_d = month_inc[4:0];
                                end
                            end else begin
                                day_d = day_inc[5:0];
                            end
                        end else begin
                            hour_d = hour_inc[5:0];
                        end
                    end else begin
                        min_d = min_inc[6:0];
                    end
                end else begin
                    sec_d = sec_inc[6:0];
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNSYNC;
            time_valid_q <= 1'b0;
            presc_q      <= '0;
            sec_q        <= 7'h00;
            min_q        <= 7'h00;
            hour_q       <= 6'h00;
            day_q        <= 6'h01;
            wday_q       <= 3'd1;
            month_q      <= 5'h01;
            year_q       <= 8'h00;
            cest_q       <= 1'b0;
            miss_q       <= 8'd0;
            sec_tick_q   <= 1'b0;
            min_tick_q   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
            wday_q     <= wday_d;
            month_q    <= month_d;
            year_q     <= year_d;
            cest_q     <= cest_d;
            miss_q     <= miss_d;
            sec_tick_q <= sec_tick_d;
            min_tick_q <= min_tick_d;
            if (clk_en) begin
                // Loss-of-sync thresholds use the post-increment miss count.
                case (state_q)
                    ST_UNSYNC: begin
                        if (sync) state_q <= ST_CANDIDATE;
                    end
                    ST_CANDIDATE: begin
                        if (sync && frame_match) begin
                            state_q      <= ST_LOCKED;
                            time_valid_q <= 1'b1;
                        end else if (!sync && miss_d >= CAND_LIM) begin
                            state_q <= ST_UNSYNC;
                        end
                    end
                    ST_LOCKED: begin
                        if (!sync && miss_d >= MISS_LIM) state_q <= ST_HOLDOVER;
                    end
                    ST_HOLDOVER: begin
                        if (sync) begin
                            state_q <= ST_LOCKED;
                        end else if (miss_d >= HOLD_LIM) begin
                            state_q      <= ST_UNSYNC;
                            time_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= ST_UNSYNC;
                        time_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sec        = sec_q;
    assign min        = min_q;
    assign hour       = hour_q;
    assign day        = day_q;
    assign wday       = wday_q;
    assign month      = month_q;
    assign year       = year_q;
    assign cest       = cest_q;
    assign sec_tick   = sec_tick_q;
    assign min_tick   = min_tick_q;
    assign status     = state_q;
    assign time_valid = time_valid_q;

endmodule

// File: tb/tb_dcf77_timekeeper.sv
// Bench for dcf77_timekeeper: directed calendar/lock scenarios plus random
// runs, all checked against an integer seconds-of-day reference model.
module tb_dcf77_timekeeper;

    localparam int TPS          = 100;
    localparam int MISS_MIN     = 2;
    localparam int HOLDOVER_MIN = 3;

    logic        clk = 1'b0;
    logic        rst, clk_en, sync;
    logic [58:0] data_hold;
    logic [6:0]  sec, min;
    logic [5:0]  hour, day;
    logic [2:0]  wday;
    logic [4:0]  month;
    logic [7:0]  year;
    logic        cest, sec_tick, min_tick, time_valid;
    logic [1:0]  status;

    dcf77_timekeeper #(
        .TICKS_PER_SEC(TPS), .MISS_MIN(MISS_MIN), .HOLDOVER_MIN(HOLDOVER_MIN)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sync(sync), .data_hold(data_hold),
        .sec(sec), .min(min), .hour(hour), .day(day), .wday(wday), .month(month),
        .year(year), .cest(cest), .sec_tick(sec_tick), .min_tick(min_tick),
        .status(status), .time_valid(time_valid)
    );

    always #5 clk = ~clk;

    wire [42:0] dut_time = {sec, min, hour, day, wday, month, year, cest};
    localparam logic [42:0] RESET_TIME = {7'h00, 7'h00, 6'h00, 6'h01, 3'd1, 5'h01, 8'h00, 1'b0};

    int n_cmp = 0;
    int n_fail = 0;
    int dut_sec_ticks = 0, dut_min_ticks = 0, exp_sec_ticks = 0, exp_min_ticks = 0;
    int m_presc, m_sec, m_min, m_hour, m_day, m_wday, m_month, m_year, m_miss, m_status;
    bit m_cest;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int month_days(input int mo, input int yr);
        int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && yr % 4 == 0) return 29;
        return lens[mo - 1];
    endfunction

    function automatic logic [58:0] make_frame(input int mi, input int h, input int d,
                                               input int w, input int mo, input int y,
                                               input bit c);
        logic [58:0] f;
        logic [7:0]  b;
        f = 59'({$urandom(), $urandom()});
        b = to_bcd(mi); f[27:21] = b[6:0];
        b = to_bcd(h);  f[34:29] = b[5:0];
        b = to_bcd(d);  f[41:36] = b[5:0];
        f[44:42] = 3'(w);
        b = to_bcd(mo); f[49:45] = b[4:0];
        b = to_bcd(y);  f[57:50] = b;
        f[17] = c;
        return f;
    endfunction

    function automatic logic [42:0] exp_time();
        logic [7:0] s, mi, h, d, mo, y;
        s = to_bcd(m_sec); mi = to_bcd(m_min); h = to_bcd(m_hour);
        d = to_bcd(m_day); mo = to_bcd(m_month); y = to_bcd(m_year);
        return {s[6:0], mi[6:0], h[5:0], d[5:0], 3'(m_wday), mo[4:0], y, m_cest};
    endfunction

    task automatic model_reset();
        m_presc = 0; m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_wday = 1;
        m_month = 1; m_year = 0; m_cest = 1'b0; m_miss = 0; m_status = 0;
    endtask

    task automatic model_step(input bit s, input logic [58:0] f);
        int nm, nh, nd, nw, nmo, ny, sod;
        if (s) begin
            nm = from_bcd({1'b0, f[27:21]});   nh = from_bcd({2'b00, f[34:29]});
            nd = from_bcd({2'b00, f[41:36]});  nw = int'(f[44:42]);
            nmo = from_bcd({3'b000, f[49:45]}); ny = from_bcd(f[57:50]);
            if (m_status == 0) m_status = 1;
            else if (m_status == 1)
                m_status = (nm == m_min && nh == m_hour && nd == m_day && nw == m_wday &&
                            nmo == m_month && ny == m_year) ? 2 : 1;
            else m_status = 2;
            m_min = nm; m_hour = nh; m_day = nd; m_wday = nw; m_month = nmo; m_year = ny;
            m_cest = f[17]; m_sec = 0; m_presc = 0; m_miss = 0;
        end else begin
            m_presc++;
            if (m_presc == TPS) begin
                m_presc = 0;
                exp_sec_ticks++;
                sod = m_hour * 3600 + m_min * 60 + m_sec + 1;
                if (sod % 60 == 0) begin
                    exp_min_ticks++;
                    if (m_miss < 255) m_miss++;
                end
                if (sod == 86400) begin
                    sod = 0;
                    m_wday = (m_wday % 7) + 1;
                    m_day++;
                    if (m_day > month_days(m_month, m_year)) begin
                        m_day = 1;
                        m_month++;
                        if (m_month > 12) begin
                            m_month = 1;
                            m_year = (m_year + 1) % 100;
                        end
                    end
                end
                m_hour = sod / 3600; m_min = (sod / 60) % 60; m_sec = sod % 60;
            end
            if (m_status == 1 && m_miss >= 2) m_status = 0;
            else if (m_status == 2 && m_miss >= MISS_MIN) m_status = 3;
            else if (m_status == 3 && m_miss >= HOLDOVER_MIN) m_status = 0;
        end
    endtask

    task automatic en_cycle(input bit s, input logic [58:0] f);
        @(negedge clk);
        clk_en = 1'b1; sync = s; data_hold = f;
        @(posedge clk); #1;
        clk_en = 1'b0; sync = 1'b0;
        if (sec_tick) dut_sec_ticks++;
        if (min_tick) dut_min_ticks++;
        model_step(s, f);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) en_cycle(1'b0, 59'({$urandom(), $urandom()}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (sec_tick) dut_sec_ticks++;
            if (min_tick) dut_min_ticks++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; sync = 1'b0; data_hold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_reset();
        n_cmp++; if (dut_time !== RESET_TIME) begin n_fail++;
            $display("FAIL reset_time: got %h expected %h", dut_time, RESET_TIME); end
        n_cmp++; if (status !== 2'd0 || time_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_status: got %0d/%0b expected 0/0", status, time_valid); end
        run_en(150);
        n_cmp++; if (sec !== 7'h01 || dut_time !== exp_time()) begin n_fail++;
            $display("FAIL idle_150_time: got %h expected %h", dut_time, exp_time()); end
        n_cmp++; if (dut_sec_ticks !== 1 || dut_min_ticks !== 0) begin n_fail++;
            $display("FAIL idle_150_ticks: got %0d/%0d expected 1/0", dut_sec_ticks, dut_min_ticks); end
        n_cmp++; if (status !== 2'd0 || time_valid !== 1'b0) begin n_fail++;
            $display("FAIL idle_150_status: got %0d/%0b expected 0/0", status, time_valid); end
        run_en(49);
        n_cmp++; if (dut_sec_ticks !== 1) begin n_fail++;
            $display("FAIL presc_at_50_early: got %0d sec_ticks expected 1", dut_sec_ticks); end
        run_en(1);
        n_cmp++; if (dut_sec_ticks !== 2 || dut_sec_ticks !== exp_sec_ticks) begin n_fail++;
            $display("FAIL presc_at_50_wrap: got %0d sec_ticks expected 2", dut_sec_ticks); end
    endtask

    task automatic test_lock();
        en_cycle(1'b1, make_frame(34, 12, 15, 6, 6, 24, 1'b1));
        n_cmp++; if (status !== 2'd1 || time_valid !== 1'b0) begin n_fail++;
            $display("FAIL lock_candidate: got %0d/%0b expected 1/0", status, time_valid); end
        run_en(6000);
        en_cycle(1'b1, make_frame(35, 12, 15, 6, 6, 24, 1'b1));
        n_cmp++; if (status !== 2'd2 || time_valid !== 1'b1) begin n_fail++;
            $display("FAIL lock_locked: got %0d/%0b expected 2/1", status, time_valid); end
        n_cmp++; if (dut_time !== {7'h00, 7'h35, 6'h12, 6'h15, 3'd6, 5'h06, 8'h24, 1'b1}) begin n_fail++;
            $display("FAIL lock_time: got %h expected 12:35:00 15.06.24 Sat", dut_time); end
        n_cmp++; if (dut_min_ticks !== exp_min_ticks || dut_sec_ticks !== exp_sec_ticks) begin n_fail++;
            $display("FAIL lock_ticks: got %0d/%0d expected %0d/%0d", dut_sec_ticks, dut_min_ticks,
                     exp_sec_ticks, exp_min_ticks); end
    endtask

    task automatic test_rollover();
        en_cycle(1'b1, make_frame(59, 23, 28, 3, 2, 24, 1'b0));
        run_en(6000);
        n_cmp++; if (dut_time !== {7'h00, 7'h00, 6'h00, 6'h29, 3'd4, 5'h02, 8'h24, 1'b0} ||
                     dut_time !== exp_time()) begin n_fail++;
            $display("FAIL roll_leap: got %h expected 00:00:00 29.02.24 Thu", dut_time); end
        en_cycle(1'b1, make_frame(59, 23, 28, 2, 2, 23, 1'b1));
        run_en(6000);
        n_cmp++; if (dut_time !== {7'h00, 7'h00, 6'h00, 6'h01, 3'd3, 5'h03, 8'h23, 1'b1}) begin n_fail++;
            $display("FAIL roll_nonleap: got %h expected 00:00:00 01.03.23 Wed", dut_time); end
        en_cycle(1'b1, make_frame(59, 23, 31, 5, 12, 99, 1'b0));
        run_en(6000);
        n_cmp++; if (dut_time !== {7'h00, 7'h00, 6'h00, 6'h01, 3'd6, 5'h01, 8'h00, 1'b0}) begin n_fail++;
            $display("FAIL roll_century: got %h expected 00:00:00 01.01.00 Sat", dut_time); end
        n_cmp++; if (status !== 2'd2 || status !== 2'(m_status)) begin n_fail++;
            $display("FAIL roll_status: got %0d expected 2", status); end
    endtask

    task automatic test_sync_wrap();
        int st, mt;
        en_cycle(1'b1, make_frame(20, 10, 5, 1, 5, 25, 1'b0));
        run_en(5999);
        n_cmp++; if (sec !== 7'h59 || min !== 7'h20) begin n_fail++;
            $display("FAIL wrap_pre: got %h:%h expected 20:59", min, sec); end
        st = dut_sec_ticks; mt = dut_min_ticks;
        en_cycle(1'b1, make_frame(45, 10, 5, 1, 5, 25, 1'b0));
        n_cmp++; if (dut_sec_ticks !== st || dut_min_ticks !== mt) begin n_fail++;
            $display("FAIL wrap_ticks: got %0d/%0d expected %0d/%0d", dut_sec_ticks, dut_min_ticks, st, mt); end
        n_cmp++; if (sec !== 7'h00 || min !== 7'h45 || dut_time !== exp_time()) begin n_fail++;
            $display("FAIL wrap_load: got %h expected %h", dut_time, exp_time()); end
    endtask

    task automatic test_holdover();
        int mt;
        mt = dut_min_ticks;
        run_en(11999);
        n_cmp++; if (status !== 2'd2 || dut_min_ticks !== mt + 1) begin n_fail++;
            $display("FAIL hold_before: got %0d after %0d min_ticks expected 2 after 1", status, dut_min_ticks - mt); end
        run_en(1);
        n_cmp++; if (status !== 2'd3 || time_valid !== 1'b1 || dut_min_ticks !== mt + 2) begin n_fail++;
            $display("FAIL hold_enter: got %0d/%0b expected 3/1", status, time_valid); end
        en_cycle(1'b1, make_frame(0, 8, 9, 2, 7, 30, 1'b1));
        n_cmp++; if (status !== 2'd2 || dut_time !== exp_time()) begin n_fail++;
            $display("FAIL hold_resync: got %0d time %h expected 2 time %h", status, dut_time, exp_time()); end
        mt = dut_min_ticks;
        run_en(17999);
        n_cmp++; if (status !== 2'd3 || dut_min_ticks !== mt + 2) begin n_fail++;
            $display("FAIL hold_late: got %0d expected 3", status); end
        run_en(1);
        n_cmp++; if (status !== 2'd0 || time_valid !== 1'b0 || dut_min_ticks !== mt + 3) begin n_fail++;
            $display("FAIL hold_expire: got %0d/%0b expected 0/0", status, time_valid); end
    endtask

    task automatic test_async_reset();
        run_en(237);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        n_cmp++; if (dut_time !== RESET_TIME || status !== 2'd0 || time_valid !== 1'b0) begin n_fail++;
            $display("FAIL async_reset: got %h st %0d expected %h st 0", dut_time, status, RESET_TIME); end
        @(negedge clk); rst = 1'b0;
        model_reset();
        en_cycle(1'b1, make_frame(1, 2, 3, 4, 5, 6, 1'b0));
        n_cmp++; if (status !== 2'd1) begin n_fail++;
            $display("FAIL async_first_sync: got %0d expected 1", status); end
    endtask

    task automatic test_candidate_mismatch();
        en_cycle(1'b1, make_frame(34, 12, 15, 6, 6, 24, 1'b0));
        run_en(6000);
        en_cycle(1'b1, make_frame(37, 12, 15, 6, 6, 24, 1'b0));
        n_cmp++; if (status !== 2'd1 || time_valid !== 1'b0) begin n_fail++;
            $display("FAIL cand_stay: got %0d/%0b expected 1/0", status, time_valid); end
        n_cmp++; if (dut_time !== {7'h00, 7'h37, 6'h12, 6'h15, 3'd6, 5'h06, 8'h24, 1'b0}) begin n_fail++;
            $display("FAIL cand_load: got %h expected 12:37:00 15.06.24", dut_time); end
    endtask

    task automatic test_random();
        int n, kind;
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 220);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
                run_en(1);
            end
            kind = $urandom_range(0, 2);
            if (kind == 1)
                en_cycle(1'b1, make_frame(m_min, m_hour, m_day, m_wday, m_month, m_year, 1'($urandom)));
            else if (kind == 2)
                en_cycle(1'b1, make_frame($urandom_range(0, 59), $urandom_range(0, 23), $urandom_range(1, 28),
                                          $urandom_range(1, 7), $urandom_range(1, 12), $urandom_range(0, 99),
                                          1'($urandom)));
            idle($urandom_range(0, 2));
            n_cmp++; if (dut_time !== exp_time()) begin n_fail++;
                $display("FAIL rand_time[%0d]: got %h expected %h", r, dut_time, exp_time()); end
            n_cmp++; if (status !== 2'(m_status) || time_valid !== (m_status >= 2)) begin n_fail++;
                $display("FAIL rand_status[%0d]: got %0d/%0b expected %0d", r, status, time_valid, m_status); end
            n_cmp++; if (dut_sec_ticks !== exp_sec_ticks || dut_min_ticks !== exp_min_ticks) begin n_fail++;
                $display("FAIL rand_ticks[%0d]: got %0d/%0d expected %0d/%0d", r, dut_sec_ticks,
                         dut_min_ticks, exp_sec_ticks, exp_min_ticks); end
        end
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        test_reset();
        test_lock();
        test_rollover();
        test_sync_wrap();
        test_holdover();
        test_async_reset();
        test_candidate_mismatch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcf77_timekeeper.md
Name: dcf77_timekeeper

Overview:
- Local time-of-day/calendar clock disciplined by the DCF77 receiver.
- Runs free from the 10 ms clk_en tick and loads the decoded frame on each receiver sync pulse.
- Qualifies lock with a two-frame consistency check and tracks holdover when frames go missing.
- Sits between the DCF77 receiver and display/consumer logic, all in the 24 MHz domain.

Parameters:
- TICKS_PER_SEC, 100, clk_en pulses per second; prescaler wraps at TICKS_PER_SEC-1.
- MISS_MIN, 2, local minutes without sync before LOCKED->HOLDOVER (>=2).
- HOLDOVER_MIN, 60, local minutes without sync before HOLDOVER->UNSYNC (>MISS_MIN, <=255).

Ports:
- clk  in  1  clock, 24 MHz
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- clk_en  in  1  10 ms enable, one clk cycle wide
- sync  in  1  receiver frame-valid strobe, coincides with a clk_en cycle, marks second 00
- data_hold  in  59  receiver frame; bit n = DCF77 second n
- sec  out  7  BCD seconds [6:4] tens, [3:0] units
- min  out  7  BCD minutes
- hour  out  6  BCD hours
- day  out  6  BCD day of month
- wday  out  3  weekday, 1=Mon..7=Sun
- month  out  5  BCD month
- year  out  8  BCD year 00..99
- cest  out  1  summer time flag, frame bit 17, loaded on sync
- sec_tick  out  1  one-cycle pulse per local second
- min_tick  out  1  one-cycle pulse on local minute rollover
- status  out  2  0=UNSYNC, 1=CANDIDATE, 2=LOCKED, 3=HOLDOVER
- time_valid  out  1  status is LOCKED or HOLDOVER

Behaviour:
- Reset: 00:00:00, day 01, month 01, year 00, wday 1, cest 0, ticks 0, prescaler 0, miss counter 0, status UNSYNC.
- All state registered. Updates occur only in clk_en cycles; outputs change the clk edge after that clk_en.
- Prescaler: increments on clk_en. At TICKS_PER_SEC-1 it wraps to 0 and advances the second. sec_tick is asserted for that one cycle.
- Carry chain on a second advance:
  - sec 59->00 gives min+1 and min_tick.
  - min 59->00 gives hour+1.
  - hour 23->00 gives day+1 and wday+1 (7->1).
  - day past month length ->01 gives month+1.
  - month 12->01 gives year+1 (99->00).
- Month lengths: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; 28 for 02, or 29 when year is a leap year.
- Leap year: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
- No leap-second support: the local clock wraps at 59, and the next sync corrects it.
- Frame decode: min={[27:25],[24:21]}, hour={[34:33],[32:29]}, day={[41:40],[39:36]}, wday=[44:42], month={[49],[48:45]}, year={[57:54],[53:50]}.
- Load on sync: decoded fields and cest are loaded; sec=00, prescaler=0, miss counter=0. No tick pulses are generated in that cycle.
- sync wins over a coincident prescaler wrap or carry.
- Miss counter: 8-bit, saturating, increments on each min_tick, cleared on sync.
- UNSYNC:
  - sync: load -> CANDIDATE.
- CANDIDATE:
  - sync with decoded min/hour/day/wday/month/year equal to the current local values: load -> LOCKED.
  - sync that mismatches: load new candidate, stay CANDIDATE.
  - miss counter reaches 2: -> UNSYNC; time keeps running.
- LOCKED:
  - sync: load unconditionally; receiver parity is trusted.
  - miss counter reaches MISS_MIN: -> HOLDOVER.
- HOLDOVER:
  - sync: load -> LOCKED.
  - miss counter reaches HOLDOVER_MIN: -> UNSYNC.
- Time keeps counting in every state. Comparisons in CANDIDATE use pre-load values of the same cycle.
- Asynchronous rst mid-operation returns everything to reset values immediately. The first sync after release goes to CANDIDATE.
- Input range is not re-checked; the receiver guarantees BCD-valid fields when sync is asserted.

Test Plan:
- Reset, then 150 clk_en pulses with no sync -> sec=01, prescaler=50, one sec_tick, status=0, time_valid=0.
- Sync with frame 12:34 15.06.24 Sat, then 6000 clk_en, then sync with 12:35 15.06.24 -> status 1 then 2; time 12:35:00; time_valid=1.
- Same, but the second frame is 12:37 -> status stays 1; local time loads 12:37:00.
- LOCKED at 23:59 28.02.24 Wed, 6000 clk_en -> 00:00:00 29.02.24 Thu. Repeat with year 23 -> 01.03.23. Also 31.12.99 rollover -> 01.01.00.
- LOCKED, then no sync: status=3 after exactly 2 min_ticks and status=0 after 60 min_ticks. A sync during HOLDOVER -> status=2 the next cycle.
- Sync on the clk_en where prescaler=99 and sec=59 -> no sec_tick/min_tick; sec=00, min = frame value.
